// File: rtl/mem_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding, default depth, port indices.
package mem_pkg;

    localparam int unsigned DEPTH_DEFAULT = 1024;

    localparam int unsigned PORT_IF = 0;
    localparam int unsigned PORT_LS = 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_STROBE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    function automatic logic [1:0] portMask(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the port not granted last wins.
module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lastGrant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req[PORT_IF] && req[PORT_LS]) begin
            grant[PORT_IF] = lastGrant;
            grant[PORT_LS] = !lastGrant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store ports onto one word memory; one access per 4 cycles.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    reqValid,
    input  logic [1:0]    reqWrite,
    input  logic [AW-1:0] reqAddr0,
    input  logic [AW-1:0] reqAddr1,
    input  logic [31:0]   reqWdata0,
    input  logic [31:0]   reqWdata1,
    output logic [1:0]    reqReady,
    output logic [1:0]    respValid,
    output logic [31:0]   respRdata,
    output logic          respErr,
    output logic [AW-1:0] memAddress,
    output logic [31:0]   memWriteData,
    output logic          memRead,
    output logic          memWrite,
    input  logic [31:0]   memReadData,
    output logic          busy
);

    logic [1:0]    stateQ, stateD;
    logic          portQ, portD;
    logic          writeQ, writeD;
    logic [AW-1:0] addrQ, addrD;
    logic [31:0]   wdataQ, wdataD;
    logic [31:0]   rdataQ, rdataD;
    logic          errQ, errD;
    logic          lastGrantQ, lastGrantD;

    logic [1:0]    grant;
    logic          selPort;
    logic [AW-1:0] selAddr;
    logic          outOfRange;

    rr_arb2 uArb (
        .req       (reqValid),
        .lastGrant (lastGrantQ),
        .grant     (grant)
    );

    assign selPort    = grant[PORT_LS];
    assign selAddr    = selPort ? reqAddr1 : reqAddr0;
    assign outOfRange = selAddr >= AW'(DEPTH);

    // Ready is gated by rst so nothing looks accepted while reset is held.
    assign reqReady = (stateQ == ST_IDLE && !rst) ? grant : 2'b00;

    always_comb begin
        stateD     = stateQ;
        portD      = portQ;
        writeD     = writeQ;
        addrD      = addrQ;
        wdataD     = wdataQ;
        rdataD     = rdataQ;
        errD       = errQ;
        lastGrantD = lastGrantQ;
        case (stateQ)
            ST_IDLE: begin
                if ((reqValid & reqReady) != 2'b00) begin
                    portD      = selPort;
                    writeD     = reqWrite[selPort];
                    addrD      = selAddr;
                    wdataD     = selPort ? reqWdata1 : reqWdata0;
                    rdataD     = 32'd0;
                    errD       = outOfRange;
                    lastGrantD = selPort;
                    stateD     = outOfRange ? ST_RESP : ST_STROBE;
                end
            end
            ST_STROBE:  stateD = ST_CAPTURE;
            ST_CAPTURE: begin
                rdataD = writeQ ? 32'd0 : memReadData;
                stateD = ST_RESP;
            end
            default:    stateD = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ     <= ST_IDLE;
            portQ      <= 1'b0;
            writeQ     <= 1'b0;
            addrQ      <= '0;
            wdataQ     <= 32'd0;
            rdataQ     <= 32'd0;
            errQ       <= 1'b0;
            lastGrantQ <= 1'b1;
        end else begin
            stateQ     <= stateD;
            portQ      <= portD;
            writeQ     <= writeD;
            addrQ      <= addrD;
            wdataQ     <= wdataD;
            rdataQ     <= rdataD;
            errQ       <= errD;
            lastGrantQ <= lastGrantD;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign memRead      = (stateQ == ST_STROBE) && !writeQ;
    assign memWrite     = (stateQ == ST_STROBE) && writeQ;
    assign memAddress   = addrQ;
    assign memWriteData = wdataQ;
    assign respValid    = (stateQ == ST_RESP) ? portMask(portQ) : 2'b00;
    assign respRdata    = rdataQ;
    assign respErr      = (stateQ == ST_RESP) && errQ;
    assign busy         = stateQ != ST_IDLE;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1024-word behavioural memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  reqValid, reqWrite, reqReady, respValid;
    logic [31:0] reqAddr0, reqAddr1, reqWdata0, reqWdata1;
    logic [31:0] respRdata, memAddress, memWriteData, memReadData;
    logic        respErr, memRead, memWrite, busy;

    int passCnt = 0;
    int totalCnt = 0;
    int rdCycles = 0;
    int wrCycles = 0;
    int consecViol = 0;
    int bothViol = 0;
    logic prevStrobe = 1'b0;
    logic [1:0] rv;

    logic [31:0] mem [0:1023];

    mem_arbiter #(.DEPTH(1024), .AW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .reqValid     (reqValid),
        .reqWrite     (reqWrite),
        .reqAddr0     (reqAddr0),
        .reqAddr1     (reqAddr1),
        .reqWdata0    (reqWdata0),
        .reqWdata1    (reqWdata1),
        .reqReady     (reqReady),
        .respValid    (respValid),
        .respRdata    (respRdata),
        .respErr      (respErr),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memReadData  (memReadData),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Synchronous memory model: acts at the clock edge that closes the strobe cycle.
    always @(posedge clk) begin
        if (memWrite) mem[memAddress[9:0]] <= memWriteData;
        if (memRead)  memReadData <= mem[memAddress[9:0]];
    end

    always @(negedge clk) begin
        if (memRead)  rdCycles++;
        if (memWrite) wrCycles++;
        if (memRead && memWrite) bothViol++;
        if (prevStrobe && (memRead || memWrite)) consecViol++;
        prevStrobe = memRead || memWrite;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic waitResp(output logic [1:0] got);
        got = 2'b00;
        for (int i = 0; i < 8 && got == 2'b00; i++) begin
            @(negedge clk);
            got = respValid;
        end
        chk("respTimeout", {31'd0, got != 2'b00}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_A5A5;
        mem[5] = 32'hDEAD_BEEF;
        memReadData = 32'd0;
        rst = 1'b1;
        reqValid = 2'b11;
        reqWrite = 2'b00;
        reqAddr0 = 32'd0;
        reqAddr1 = 32'd0;
        reqWdata0 = 32'd0;
        reqWdata1 = 32'd0;

        // Reset state, with requests already asserted
        @(negedge clk);
        chk("rstReady", {30'd0, reqReady}, 32'd0);
        chk("rstBusy", {31'd0, busy}, 32'd0);
        chk("rstStrobes", {30'd0, memRead, memWrite}, 32'd0);
        chk("rstResp", {29'd0, respValid, respErr}, 32'd0);
        chk("rstRdata", respRdata, 32'd0);
        chk("rstAddr", memAddress, 32'd0);
        chk("rstWdata", memWriteData, 32'd0);
        rst = 1'b0;
        reqValid = 2'b00;

        // Single read, port 0, addr 5
        @(negedge clk);
        reqValid = 2'b01;
        reqAddr0 = 32'd5;
        #1 chk("rdReady", {30'd0, reqReady}, 32'd1);
        @(negedge clk);
        reqValid = 2'b00;
        chk("rdStrobe", {30'd0, memRead, memWrite}, 32'd2);
        chk("rdAddr", memAddress, 32'd5);
        chk("rdBusyReady", {29'd0, busy, reqReady}, 32'd4);
        @(negedge clk);
        chk("rdCapture", {28'd0, memRead, memWrite, respValid}, 32'd0);
        @(negedge clk);
        chk("rdRespValid", {30'd0, respValid}, 32'd1);
        chk("rdRespData", respRdata, 32'hDEAD_BEEF);
        chk("rdRespErr", {31'd0, respErr}, 32'd0);
        @(negedge clk);
        chk("rdIdle", {29'd0, busy, respValid}, 32'd0);

        // Write then read, port 1, addr 1023
        reqValid = 2'b10;
        reqWrite = 2'b10;
        reqAddr1 = 32'd1023;
        reqWdata1 = 32'h1234_5678;
        #1 chk("wrReady", {30'd0, reqReady}, 32'd2);
        @(negedge clk);
        reqValid = 2'b00;
        reqWrite = 2'b00;
        chk("wrStrobe", {30'd0, memRead, memWrite}, 32'd1);
        chk("wrData", memWriteData, 32'h1234_5678);
        chk("wrAddr", memAddress, 32'd1023);
        @(negedge clk);
        chk("wrCapture", {30'd0, memRead, memWrite}, 32'd0);
        @(negedge clk);
        chk("wrRespValid", {30'd0, respValid}, 32'd2);
        chk("wrRespData", respRdata, 32'd0);
        @(negedge clk);
        reqValid = 2'b10;
        #1 chk("rbReady", {30'd0, reqReady}, 32'd2);
        waitResp(rv);
        reqValid = 2'b00;
        chk("rbRespValid", {30'd0, rv}, 32'd2);
        chk("rbRespData", respRdata, 32'h1234_5678);

        // Contention after reset: grants alternate starting with port 0
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        reqValid = 2'b11;
        reqAddr0 = 32'd5;
        reqAddr1 = 32'd1023;
        #1 chk("ctReady", {30'd0, reqReady}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            waitResp(rv);
            if (k == 3) reqValid = 2'b00;
            chk($sformatf("ctGrant%0d", k), {30'd0, rv}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("ctData%0d", k), respRdata,
                (k % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678);
        end

        // Out-of-range read, port 1, addr 1024
        @(negedge clk);
        reqValid = 2'b10;
        reqAddr1 = 32'd1024;
        #1 chk("oorReady", {30'd0, reqReady}, 32'd2);
        @(negedge clk);
        reqValid = 2'b00;
        chk("oorRespValid", {30'd0, respValid}, 32'd2);
        chk("oorErr", {31'd0, respErr}, 32'd1);
        chk("oorRdata", respRdata, 32'd0);
        chk("oorNoStrobe", {30'd0, memRead, memWrite}, 32'd0);
        @(negedge clk);
        chk("oorIdle", {28'd0, busy, respErr, respValid}, 32'd0);
        chk("oorMemUntouched", mem[0], 32'hA5A5_A5A5);

        // Reset during STROBE
        reqValid = 2'b01;
        reqAddr0 = 32'd5;
        @(negedge clk);
        reqValid = 2'b00;
        chk("mrStrobe", {31'd0, memRead}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("mrAsyncDrop", {30'd0, memRead, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mrNoResp%0d", i), {30'd0, respValid}, 32'd0);
        end
        reqValid = 2'b11;
        #1 chk("mrGrantPort0", {30'd0, reqReady}, 32'd1);
        reqValid = 2'b00;

        // Backpressure: port 0 arrives during port 1 CAPTURE
        @(negedge clk);
        reqValid = 2'b10;
        reqAddr1 = 32'd1023;
        @(negedge clk);
        reqValid = 2'b00;
        chk("bpStrobe", {31'd0, memRead}, 32'd1);
        @(negedge clk);
        reqValid = 2'b01;
        reqAddr0 = 32'd5;
        #1 chk("bpReadyCapture", {30'd0, reqReady}, 32'd0);
        @(negedge clk);
        chk("bpReadyResp", {30'd0, reqReady}, 32'd0);
        chk("bpResp1", {30'd0, respValid}, 32'd2);
        chk("bpData1", respRdata, 32'h1234_5678);
        @(negedge clk);
        chk("bpReadyIdle", {30'd0, reqReady}, 32'd1);
        @(negedge clk);
        reqValid = 2'b00;
        waitResp(rv);
        chk("bpResp0", {30'd0, rv}, 32'd1);
        chk("bpData0", respRdata, 32'hDEAD_BEEF);

        repeat (2) @(negedge clk);
        chk("readCycles", rdCycles, 32'd9);
        chk("writeCycles", wrCycles, 32'd1);
        chk("consecStrobes", consecViol, 32'd0);
        chk("bothStrobes", bothViol, 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
